pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined WIDTH-bit add/subtract unit built from SEG_W = WIDTH/STAGES-bit segments.
//  The carry ripples one segment per clock through pipeline registers, so critical path = one segment.
//  Adds a subtract mode, signed-overflow flag and valid/ready flow control at both ends.
//  Sits between operand producers (ALU and DSP datapaths) and result consumers. Full throughput: 1 op/clk.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0 is required (elaboration error otherwise)
//  STAGES  4   pipeline depth = number of segments; >= 1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat this cycle
//  sub        in   1      0: a + b + c_in; 1: a - b - c_in (c_in is borrow-in)
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  c_out      out  1      raw carry out of MSB; in sub mode borrow-out = ~c_out
//  overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: all stage valids, data and carry regs clear; out_valid=0, sum=0, c_out=0, overflow=0.
//    in_ready=1 in the cycle after rst deasserts.
//  - Sub mode: b_eff = ~b, cin_eff = ~c_in (a + ~b + ~c_in); add mode: b_eff = b, cin_eff = c_in.
//    sub is captured with the beat.
//  - Stage k (0..STAGES-1) adds segment k of a and b_eff plus the carry registered by stage k-1 (stage 0 uses cin_eff).
//    Upper operand segments travel in skew regs; completed lower sum segments travel in deskew regs.
//  - Global stall: advance = ~v[STAGES-1] | out_ready; in_ready = advance.
//    When advance=0, every stage register holds its value.
//  - Accept on in_valid & in_ready; the beat appears on out_valid exactly STAGES cycles later if never stalled.
//    Each stalled cycle adds one cycle.
//  - out_valid = v[STAGES-1]. sum, c_out and overflow are registered and held stable while out_valid & ~out_ready.
//  - in_ready combinationally depends on out_ready (no skid buffer); no other in-to-out combinational path.
//  - Bubbles (in_valid=0 while advancing) propagate as invalid stages; data regs of invalid stages are don't-care.
//    Outputs hold their last values while out_valid=0.
//  - Wrap-around: modulo 2^WIDTH; the carry/borrow is reported, never saturated.
//  - Overflow needs carry-into-MSB, taken from the top segment's internal carry at bit WIDTH-2.
//    WIDTH=1 is allowed; then overflow = cin_eff ^ c_out.
//  - Reset mid-operation: all in-flight beats are discarded; no partial result is emitted.
//  - STAGES=1: a single registered adder, latency 1, no skew/deskew regs.
//  - Ordering: results leave in acceptance order; no beat is dropped or duplicated under any out_ready pattern.
// STRUCTURE
//  - pipelined_adder_pkg: function seg_lo(k, SEG_W) for slice offsets; localparam checks for WIDTH % STAGES.
//  - Sub-module adder_segment #(SEG_W): combinational a_seg + b_seg + cin -> {cout, s, c_msb_in}.
//    c_msb_in is the carry into the segment's top bit. Instantiated STAGES times via generate.
//  - Top: generate loop of stage regs (valid, carry, skew, deskew), global advance, output regs.
// TESTING  (WIDTH=8, STAGES=4 unless noted)
//  - Basic add: a=0xFF, b=0x01, c_in=0, sub=0.
//    -> 4 clks later out_valid=1, sum=0x00, c_out=1, overflow=0.
//  - Overflow: a=0x7F, b=0x01 -> sum=0x80, c_out=0, overflow=1; a=0x80, b=0x80 -> sum=0x00, c_out=1, overflow=1.
//  - Subtract: sub=1, a=0x05, b=0x07, c_in=0 -> sum=0xFE, c_out=0 (borrow), overflow=0.
//    sub=1, a=0x80, b=0x01 -> sum=0x7F, overflow=1.
//  - Backpressure: stream 8 random beats back-to-back with out_ready low for cycles 5-7.
//    -> in_ready low exactly while out_valid & ~out_ready; all 8 results match the reference model in order, outputs stable while stalled.
//  - Reset mid-flight: accept 3 beats, assert rst one cycle.
//    -> out_valid stays 0 for the following 6 cycles; the next accepted beat emerges after 4 clks.
//  - Degenerate: STAGES=1, WIDTH=16, a=0xFFFF, b=0x0000, c_in=1 -> next cycle sum=0x0000, c_out=1.
//    Random regression at WIDTH=32, STAGES=4/8 vs behavioural model.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared parameters and helpers for the segmented pipelined adder.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default geometry of pipelined_adder
//   seg_lo()                       : bit offset of segment k
//   cfg_ok()                       : legal geometry check (WIDTH divisible by STAGES)
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  // Low bit index of segment k.
  function automatic int unsigned seg_lo(int unsigned k, int unsigned seg_w);
    return k * seg_w;
  endfunction

  // Geometry is legal when every segment holds at least one bit and all are equal.
  function automatic bit cfg_ok(int unsigned width, int unsigned stages);
    return (stages >= 1) && (width >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit add slice.
//   a_seg, b_seg, cin : segment operands and carry-in
//   s                 : segment sum
//   cout              : carry out of the segment top bit
//   c_msb_in          : carry into the segment top bit (for signed overflow)
module adder_segment
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int unsigned FULL_W = SEG_W + 1;

  logic [SEG_W:0] full;

  // The carry into the top bit is recovered from that bit's sum: s = a ^ b ^ c.
  always_comb begin
    full     = {1'b0, a_seg} + {1'b0, b_seg} + FULL_W'(cin);
    s        = full[SEG_W-1:0];
    cout     = full[SEG_W];
    c_msb_in = full[SEG_W-1] ^ a_seg[SEG_W-1] ^ b_seg[SEG_W-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract; carry ripples one SEG_W segment per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (sub, a, b, c_in)
//   out_valid / out_ready: result handshake (sum, c_out, overflow)
// Stage k registers: valid, carry out of segment k, completed low sum bits
// (deskew) and the still-unprocessed upper operand bits (skew).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned SEG_W = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtract as a + ~b + ~borrow; inversion happens once, at capture.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = c_in ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO   = seg_lo(k, SEG_W);
    localparam int unsigned OP_W = WIDTH - LO;
    localparam int unsigned DN_W = LO + SEG_W;

    logic [OP_W-1:0]  a_in, b_in;
    logic             cin, v_in, load;
    logic [SEG_W-1:0] s_seg;
    logic             cout, c_msb;
    logic [DN_W-1:0]  s_new;
    logic             v_d, v_q, c_d, c_q;
    logic [DN_W-1:0]  s_d, s_q;

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_eff;
      assign cin   = cin_eff;
      assign v_in  = in_valid;
      assign s_new = s_seg;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_skew.a_q;
      assign b_in  = g_stage[k-1].g_skew.b_q;
      assign cin   = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_new = {s_seg, g_stage[k-1].s_q};
    end

    adder_segment #(.SEG_W(SEG_W)) u_seg (
      .a_seg    (a_in[SEG_W-1:0]),
      .b_seg    (b_in[SEG_W-1:0]),
      .cin      (cin),
      .s        (s_seg),
      .cout     (cout),
      .c_msb_in (c_msb)
    );

    // Data only loads for valid beats so the last stage holds across bubbles.
    assign load = advance & v_in;

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (advance) v_d = v_in;
      if (load) begin
        c_d = cout;
        s_d = s_new;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned HI_W = OP_W - SEG_W;
      logic [HI_W-1:0] a_d, a_q, b_d, b_q;
      logic            c_msb_unused;

      // Only the top segment's internal carry matters for overflow.
      assign c_msb_unused = c_msb;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
          a_d = a_in[OP_W-1:SEG_W];
          b_d = b_in[OP_W-1:SEG_W];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (load) ovf_d = c_msb ^ cout;
      end

      always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end
    end
  end

  // Global stall: the whole pipe moves unless a finished result is blocked.
  assign advance   = ~g_stage[STAGES-1].v_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: four instances (8/4, 16/1, 32/4, 32/8)
// driven concurrently; expected results come from signed/unsigned integer math.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        of;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;

  function automatic int unsigned cfg_w(input int g);
    case (g)
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned cfg_s(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv [4];
  logic        sb [4];
  logic        ci [4];
  logic        orr[4];
  logic [31:0] av [4];
  logic [31:0] bv [4];
  logic        ir [4];
  logic        ov [4];
  logic        co [4];
  logic        of [4];
  logic [31:0] sm [4];

  exp_t        q [4][$];
  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rand_or = 1'b0;
  logic        held_v [4];
  logic [34:0] held_d [4];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W = cfg_w(g);
    localparam int unsigned S = cfg_s(g);
    logic [W-1:0] sum_w;
    logic         ir_w, ov_w, co_w, of_w;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir_w),
      .sub       (sb[g]),
      .a         (av[g][W-1:0]),
      .b         (bv[g][W-1:0]),
      .c_in      (ci[g]),
      .out_valid (ov_w),
      .out_ready (orr[g]),
      .sum       (sum_w),
      .c_out     (co_w),
      .overflow  (of_w)
    );

    assign ir[g] = ir_w;
    assign ov[g] = ov_w;
    assign co[g] = co_w;
    assign of[g] = of_w;
    assign sm[g] = 32'(sum_w);
  end

  function automatic logic [31:0] msk(input int w);
    longint t;
    t = (longint'(1) << w) - 1;
    return t[31:0];
  endfunction

  // Reference: exact integer arithmetic, then reduce modulo 2^w.
  function automatic exp_t ref_model(input int w, input logic s, input logic [31:0] x,
                                     input logic [31:0] y, input logic c);
    exp_t   e;
    longint m, ux, uy, sx, sy, lc, ur, sr;
    e  = '0;
    m  = longint'(1) << w;
    ux = {32'd0, x};
    uy = {32'd0, y};
    lc = c ? 1 : 0;
    sx = x[w-1] ? ux - m : ux;
    sy = y[w-1] ? uy - m : uy;
    if (s) begin
      ur   = ux - uy - lc;
      sr   = sx - sy - lc;
      e.co = (ur >= 0);
    end else begin
      ur   = ux + uy + lc;
      sr   = sx + sy + lc;
      e.co = (ur >= m);
    end
    e.of = (sr >= m / 2) || (sr < -(m / 2));
    ur = ur % m;
    if (ur < 0) ur = ur + m;
    e.sum = ur[31:0];
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s_v, input logic co_v, input logic of_v, input int lat);
    exp_t e;
    e     = '0;
    e.sum = s_v;
    e.co  = co_v;
    e.of  = of_v;
    e.lat = 32'(lat);
    return e;
  endfunction

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h want %0h (cycle %0d)", name, g, act, want, cyc);
    end
  endtask

  // Drive one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input int g, input logic s, input logic [31:0] x, input logic [31:0] y,
                      input logic c, input exp_t e, input bit push);
    int   n;
    exp_t ee;
    iv[g] = 1'b1;
    sb[g] = s;
    av[g] = x;
    bv[g] = y;
    ci[g] = c;
    n = 0;
    #1;
    while (!ir[g] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ir[g]) begin
      errs++;
      checks++;
      $display("FAIL accept_timeout dut%0d: in_ready stuck low for %0d cycles", g, n);
      iv[g] = 1'b0;
      return;
    end
    if (push) begin
      ee     = e;
      ee.acc = 32'(cyc + 1);
      q[g].push_back(ee);
    end
    @(negedge clk);
  endtask

  task automatic rand_stream(input int g, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int          gap, w;
      logic [31:0] x, y;
      logic        s, c;
      w   = int'(cfg_w(g));
      gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max));
      if (gap != 0) begin
        iv[g] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      x = $urandom() & msk(w);
      y = $urandom() & msk(w);
      s = 1'($urandom());
      c = 1'($urandom());
      send(g, s, x, y, c, ref_model(w, s, x, y, c), 1'b1);
    end
    iv[g] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      errs++;
      checks++;
      $display("FAIL drain_timeout: %0d results still outstanding", q[0].size() + q[1].size() + q[2].size() + q[3].size());
    end
  endtask

  // Monitor: pops and compares on every output handshake, checks flow control and hold.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rand_or) for (int g = 0; g < 4; g++) orr[g] = ($urandom_range(3) != 0);
      #1;
      for (int g = 0; g < 4; g++) begin
        if (rst) begin
          held_v[g] = 1'b0;
        end else begin
          if (held_v[g]) chk("hold", g, 64'({ov[g], co[g], of[g], sm[g]}), 64'(held_d[g]));
          chk("in_ready", g, 64'(ir[g]), 64'(!(ov[g] && !orr[g])));
          if (ov[g] && orr[g]) begin
            chk("beat_expected", g, 64'(q[g].size() != 0), 64'd1);
            if (q[g].size() != 0) begin
              e = q[g].pop_front();
              chk("sum", g, 64'(sm[g]), 64'(e.sum));
              chk("c_out", g, 64'(co[g]), 64'(e.co));
              chk("overflow", g, 64'(of[g]), 64'(e.of));
              if (e.lat != 0) chk("latency", g, 64'(cyc + 1 - int'(e.acc)), 64'(e.lat));
            end
          end
          held_v[g] = ov[g] && !orr[g];
          held_d[g] = {ov[g], co[g], of[g], sm[g]};
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      iv[g] = 1'b0; sb[g] = 1'b0; ci[g] = 1'b0; orr[g] = 1'b1;
      av[g] = '0;   bv[g] = '0;   held_v[g] = 1'b0;
    end
    fork
      monitor();
      begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
          chk("reset_out_valid", g, 64'(ov[g]), 64'd0);
          chk("reset_sum", g, 64'(sm[g]), 64'd0);
          chk("reset_c_out", g, 64'(co[g]), 64'd0);
          chk("reset_overflow", g, 64'(of[g]), 64'd0);
          chk("reset_in_ready", g, 64'(ir[g]), 64'd1);
        end
        @(negedge clk);

        // Directed corner cases with hand-computed results.
        send(0, 1'b0, 32'hFF, 32'h01, 1'b0, mk(32'h00, 1'b1, 1'b0, 4), 1'b1);
        send(0, 1'b0, 32'h7F, 32'h01, 1'b0, mk(32'h80, 1'b0, 1'b1, 4), 1'b1);
        send(0, 1'b0, 32'h80, 32'h80, 1'b0, mk(32'h00, 1'b1, 1'b1, 4), 1'b1);
        send(0, 1'b1, 32'h05, 32'h07, 1'b0, mk(32'hFE, 1'b0, 1'b0, 4), 1'b1);
        send(0, 1'b1, 32'h80, 32'h01, 1'b0, mk(32'h7F, 1'b1, 1'b1, 4), 1'b1);
        iv[0] = 1'b0;
        send(1, 1'b0, 32'hFFFF, 32'h0000, 1'b1, mk(32'h0000, 1'b1, 1'b0, 1), 1'b1);
        iv[1] = 1'b0;
        send(2, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, mk(32'h0, 1'b1, 1'b0, 4), 1'b1);
        send(2, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, mk(32'h80000000, 1'b0, 1'b1, 4), 1'b1);
        iv[2] = 1'b0;
        send(3, 1'b1, 32'h0, 32'h0, 1'b1, mk(32'hFFFFFFFF, 1'b0, 1'b0, 8), 1'b1);
        iv[3] = 1'b0;
        drain();

        // Back-to-back stream with out_ready low for three cycles.
        fork
          rand_stream(0, 8, 0);
          begin
            repeat (5) @(negedge clk);
            orr[0] = 1'b0;
            repeat (3) @(negedge clk);
            orr[0] = 1'b1;
          end
        join
        drain();

        // Reset with three beats in flight: nothing may emerge.
        send(0, 1'b0, 32'h11, 32'h22, 1'b0, mk(32'h0, 1'b0, 1'b0, 0), 1'b0);
        send(0, 1'b1, 32'h40, 32'h03, 1'b1, mk(32'h0, 1'b0, 1'b0, 0), 1'b0);
        send(0, 1'b0, 32'hF0, 32'h20, 1'b0, mk(32'h0, 1'b0, 1'b0, 0), 1'b0);
        iv[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
          #1;
          chk("rst_flush", 0, 64'(ov[0]), 64'd0);
          @(negedge clk);
        end
        e = ref_model(8, 1'b0, 32'h3C, 32'h0F, 1'b1);
        e.lat = 32'd4;
        send(0, 1'b0, 32'h3C, 32'h0F, 1'b1, e, 1'b1);
        iv[0] = 1'b0;
        drain();

        // Random regression with random bubbles and backpressure on all geometries.
        rand_or = 1'b1;
        fork
          rand_stream(0, 60, 2);
          rand_stream(1, 60, 2);
          rand_stream(2, 60, 2);
          rand_stream(3, 60, 2);
        join
        rand_or = 1'b0;
        for (int g = 0; g < 4; g++) orr[g] = 1'b1;
        drain();
        for (int g = 0; g < 4; g++) chk("leftover", g, 64'(q[g].size()), 64'd0);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
